issue_queue: RTL and testbench

Instruction issue queue and pairing scheduler between fetch and decode in the dual-issue MIPS pipeline. It accepts up to two fetched instructions per cycle into a circular buffer. Each cycle it issues either an instruction pair or one instruction to the two decode slots, applying the slot-pairing rules: branch/jump alone, one memory op per pair, no intra-pair RAW. It also honours decode stalls and branch-mispredict flushes from the hazard unit.

---
 rtl/issue_queue.sv | 156 +++++++++++++++
 tb/tb_issue_queue.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/issue_queue.sv
// Dual-issue instruction queue: circular buffer fed by fetch pairs, issuing one or two
// instructions per cycle to decode under the slot-pairing rules. Optional ISSUE_STATS_EN adds issue counters.
module issue_queue #(
  parameter int DEPTH = 8,
  parameter int PCW   = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     FetchValidF,
  input  logic [31:0]              InstrF_1,
  input  logic [31:0]              InstrF_2,
  input  logic [PCW-1:0]           PCF,
  output logic                     FetchReadyF,
  input  logic                     stallD,
  input  logic                     flushQ,
  output logic [31:0]              InstrD_1,
  output logic [31:0]              InstrD_2,
  output logic [PCW-1:0]           PCD_1,
  output logic [PCW-1:0]           PCD_2,
  output logic                     ValidD_1,
  output logic                     ValidD_2,
  output logic [$clog2(DEPTH):0]   CountQ
`ifdef ISSUE_STATS_EN
  ,
  output logic [15:0]              DualCnt,
  output logic [15:0]              SingleCnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]    instrMem [DEPTH];
  logic [PCW-1:0] pcMem    [DEPTH];
  logic [AW-1:0]  rdPtr, wrPtr, rdNext;
  logic [CW-1:0]  count;
  logic           push, canIssue, dual;
  logic [1:0]     popped;
  logic [31:0]    e0, e1;
  logic [PCW-1:0] pc0, pc1;

  function automatic logic isBranch(input logic [5:0] op, input logic [5:0] funct);
    return (op == 6'h04) || (op == 6'h05) || (op == 6'h02) || (op == 6'h03) ||
           ((op == 6'h00) && (funct == 6'h08));
  endfunction

  function automatic logic isMem(input logic [5:0] op);
    return (op == 6'h23) || (op == 6'h2b);
  endfunction

  // A zero result means "no destination"; writes to $0 are harmless for pairing.
  function automatic logic [4:0] destReg(input logic [5:0] op, input logic [5:0] funct,
                                         input logic [4:0] rt, input logic [4:0] rd);
    logic [4:0] d;
    d = 5'd0;
    case (op)
      6'h00: d = (funct == 6'h08) ? 5'd0 : rd;
      6'h08, 6'h09, 6'h0a, 6'h0c, 6'h0d, 6'h0f, 6'h23: d = rt;
      6'h03: d = 5'd31;
      default: d = 5'd0;
    endcase
    return d;
  endfunction

  function automatic logic usesRt(input logic [5:0] op);
    return (op == 6'h00) || (op == 6'h2b) || (op == 6'h04) || (op == 6'h05);
  endfunction

  assign rdNext      = rdPtr + AW'(1);
  assign e0          = instrMem[rdPtr];
  assign e1          = instrMem[rdNext];
  assign pc0         = pcMem[rdPtr];
  assign pc1         = pcMem[rdNext];
  assign FetchReadyF = (count <= CW'(DEPTH - 2));
  assign CountQ      = count;
  assign push        = FetchValidF & FetchReadyF;
  assign canIssue    = !stallD && (count != '0);

  logic [4:0] dest0;
  logic       raw;
  assign dest0 = destReg(e0[31:26], e0[5:0], e0[20:16], e0[15:11]);
  assign raw   = (dest0 != 5'd0) &&
                 ((dest0 == e1[25:21]) || (usesRt(e1[31:26]) && (dest0 == e1[20:16])));

  assign dual = (count >= CW'(2)) &&
                !isBranch(e0[31:26], e0[5:0]) &&
                !isBranch(e1[31:26], e1[5:0]) &&
                !(isMem(e0[31:26]) && isMem(e1[31:26])) &&
                !raw;

  assign popped = !canIssue ? 2'd0 : (dual ? 2'd2 : 2'd1);

  // Storage needs no reset: occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push && !flushQ) begin
      instrMem[wrPtr]          <= InstrF_1;
      instrMem[wrPtr + AW'(1)] <= InstrF_2;
      pcMem[wrPtr]             <= PCF;
      pcMem[wrPtr + AW'(1)]    <= PCF + PCW'(4);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (flushQ) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      rdPtr <= rdPtr + AW'(popped);
      if (push) wrPtr <= wrPtr + AW'(2);
      count <= count + (push ? CW'(2) : CW'(0)) - CW'(popped);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ValidD_1 <= 1'b0;
      ValidD_2 <= 1'b0;
      InstrD_1 <= '0;
      InstrD_2 <= '0;
      PCD_1    <= '0;
      PCD_2    <= '0;
    end else if (flushQ || (!stallD && (count == '0))) begin
      ValidD_1 <= 1'b0;
      ValidD_2 <= 1'b0;
      InstrD_1 <= '0;
      InstrD_2 <= '0;
      PCD_1    <= '0;
      PCD_2    <= '0;
    end else if (canIssue) begin
      ValidD_1 <= 1'b1;
      InstrD_1 <= e0;
      PCD_1    <= pc0;
      ValidD_2 <= dual;
      InstrD_2 <= dual ? e1 : '0;
      PCD_2    <= dual ? pc1 : '0;
    end
  end

`ifdef ISSUE_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      DualCnt   <= '0;
      SingleCnt <= '0;
    end else if (!flushQ && canIssue) begin
      if (dual && (DualCnt != 16'hFFFF)) DualCnt <= DualCnt + 16'd1;
      if (!dual && (SingleCnt != 16'hFFFF)) SingleCnt <= SingleCnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_issue_queue.sv
// Scoreboard bench for issue_queue: directed pairs push expected issue groups,
// a monitor compares each freshly loaded decode bundle.
module tb_issue_queue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        FetchValidF;
  logic [31:0] InstrF_1, InstrF_2, PCF;
  logic        FetchReadyF;
  logic        stallD, flushQ;
  logic [31:0] InstrD_1, InstrD_2, PCD_1, PCD_2;
  logic        ValidD_1, ValidD_2;
  logic [3:0]  CountQ;
`ifdef ISSUE_STATS_EN
  logic [15:0] DualCnt, SingleCnt;
`endif

  int total = 0;
  int bad   = 0;
  int expDual = 0;
  int expSingle = 0;

  typedef struct {
    logic        v2;
    logic [31:0] i1, p1, i2, p2;
  } grp_t;
  grp_t sb[$];

  issue_queue #(.DEPTH(8), .PCW(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .FetchValidF(FetchValidF), .InstrF_1(InstrF_1), .InstrF_2(InstrF_2), .PCF(PCF),
    .FetchReadyF(FetchReadyF), .stallD(stallD), .flushQ(flushQ),
    .InstrD_1(InstrD_1), .InstrD_2(InstrD_2), .PCD_1(PCD_1), .PCD_2(PCD_2),
    .ValidD_1(ValidD_1), .ValidD_2(ValidD_2), .CountQ(CountQ)
`ifdef ISSUE_STATS_EN
    , .DualCnt(DualCnt), .SingleCnt(SingleCnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int funct);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(funct)};
  endfunction

  function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pushPair(input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc);
    FetchValidF = 1'b1; InstrF_1 = a; InstrF_2 = b; PCF = pc;
    step();
    FetchValidF = 1'b0;
  endtask

  task automatic expect1(input logic [31:0] i, input logic [31:0] p);
    grp_t g;
    g.v2 = 1'b0; g.i1 = i; g.p1 = p; g.i2 = '0; g.p2 = '0;
    sb.push_back(g);
    expSingle++;
  endtask

  task automatic expect2(input logic [31:0] a, input logic [31:0] pa,
                         input logic [31:0] b, input logic [31:0] pb);
    grp_t g;
    g.v2 = 1'b1; g.i1 = a; g.p1 = pa; g.i2 = b; g.p2 = pb;
    sb.push_back(g);
    expDual++;
  endtask

  task automatic drain();
    int n = 0;
    while (CountQ != 0 && n < 50) begin
      step();
      n++;
    end
    chk("drain_count", 32'(CountQ), 32'd0);
    step();
    step();
  endtask

  // Only bundles loaded by an unstalled, unflushed edge are new decode traffic.
  always @(posedge clk) begin
    logic upd;
    grp_t g;
    upd = reset_n && !stallD && !flushQ;
    #2;
    if (upd && ValidD_1) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_issue: got instr %h pc %h want none", InstrD_1, PCD_1);
      end else begin
        g = sb.pop_front();
        chk("slot1_instr", InstrD_1, g.i1);
        chk("slot1_pc", PCD_1, g.p1);
        chk("slot2_valid", 32'(ValidD_2), 32'(g.v2));
        chk("slot2_instr", InstrD_2, g.i2);
        if (g.v2) chk("slot2_pc", PCD_2, g.p2);
      end
    end else if (upd) begin
      chk("slot2_valid_idle", 32'(ValidD_2), 32'd0);
    end
  end

  initial begin
    logic [31:0] addA, subB, lwI, swI, addiI, addDep, addZ, beqI, a1, a2, a3;
    addA   = rtype(1, 2, 3, 32'h20);
    subB   = rtype(4, 6, 5, 32'h22);
    lwI    = itype(32'h23, 1, 2, 0);
    swI    = itype(32'h2b, 1, 3, 4);
    addiI  = itype(32'h08, 0, 7, 5);
    addDep = rtype(7, 7, 8, 32'h20);
    addZ   = rtype(0, 0, 8, 32'h20);
    beqI   = itype(32'h04, 1, 2, 8);

    reset_n = 1'b0; FetchValidF = 1'b0; InstrF_1 = '0; InstrF_2 = '0; PCF = '0;
    stallD = 1'b0; flushQ = 1'b0;
    repeat (3) step();
    chk("rst_ready", 32'(FetchReadyF), 32'd1);
    chk("rst_count", 32'(CountQ), 32'd0);
    chk("rst_valid1", 32'(ValidD_1), 32'd0);
    chk("rst_instr1", InstrD_1, 32'd0);
    chk("rst_pc2", PCD_2, 32'd0);
    reset_n = 1'b1;
    step();

    // independent R-types pair up
    expect2(addA, 32'h100, subB, 32'h104);
    pushPair(addA, subB, 32'h100);
    step();
    chk("dual_count_after", 32'(CountQ), 32'd0);
    drain();

    // two memory ops never share a pair
    expect1(lwI, 32'h200);
    expect1(swI, 32'h204);
    pushPair(lwI, swI, 32'h200);
    drain();

    // RAW inside the pair splits it; $0 sources do not
    expect1(addiI, 32'h300);
    expect1(addDep, 32'h304);
    pushPair(addiI, addDep, 32'h300);
    drain();
    expect2(addiI, 32'h310, addZ, 32'h314);
    pushPair(addiI, addZ, 32'h310);
    drain();

    // branches only ever issue alone in slot 1
    a1 = rtype(1, 2, 11, 32'h20);
    a2 = rtype(1, 2, 9, 32'h20);
    a3 = rtype(3, 4, 10, 32'h20);
    expect1(a1, 32'h400);
    expect1(beqI, 32'h404);
    expect2(a2, 32'h408, a3, 32'h40c);
    pushPair(a1, beqI, 32'h400);
    pushPair(a2, a3, 32'h408);
    drain();

    // stall with odd occupancy, refused push at 7, flush
    a1 = rtype(1, 2, 12, 32'h20);
    expect1(a1, 32'h500);
    pushPair(a1, beqI, 32'h500);
    step();
    stallD = 1'b1;
    for (int k = 0; k < 3; k++) pushPair(addA, subB, 32'h600 + 32'(8 * k));
    chk("stall_count7", 32'(CountQ), 32'd7);
    chk("stall_ready7", 32'(FetchReadyF), 32'd0);
    chk("stall_frozen_v1", 32'(ValidD_1), 32'd1);
    chk("stall_frozen_i1", InstrD_1, a1);
    pushPair(addA, subB, 32'h680);
    chk("refused_push", 32'(CountQ), 32'd7);
    flushQ = 1'b1;
    step();
    flushQ = 1'b0;
    chk("flush1_count", 32'(CountQ), 32'd0);
    chk("flush1_valid1", 32'(ValidD_1), 32'd0);
    for (int k = 0; k < 4; k++) pushPair(addA, subB, 32'h700 + 32'(8 * k));
    chk("full_count8", 32'(CountQ), 32'd8);
    chk("full_ready8", 32'(FetchReadyF), 32'd0);
    chk("full_frozen_v1", 32'(ValidD_1), 32'd0);
    // flushQ with a push offered: flush must win and drop the pair
    flushQ = 1'b1;
    stallD = 1'b0;
    step();
    flushQ = 1'b0;
    chk("flush2_count", 32'(CountQ), 32'd0);
    chk("flush2_valid1", 32'(ValidD_1), 32'd0);
    chk("flush2_valid2", 32'(ValidD_2), 32'd0);
    FetchValidF = 1'b1; InstrF_1 = addA; InstrF_2 = subB; PCF = 32'h780;
    flushQ = 1'b1;
    step();
    flushQ = 1'b0; FetchValidF = 1'b0;
    chk("flush_push_dropped", 32'(CountQ), 32'd0);
    repeat (4) step();
    chk("flush_idle_count", 32'(CountQ), 32'd0);

    // back-to-back pairs walking the pointers around the ring
    for (int k = 0; k < 6; k++) begin
      a1 = rtype(1, 2, 13 + 2 * k, 32'h20);
      a2 = rtype(1, 2, 14 + 2 * k, 32'h20);
      expect2(a1, 32'h800 + 32'(8 * k), a2, 32'h804 + 32'(8 * k));
    end
    for (int k = 0; k < 6; k++)
      pushPair(rtype(1, 2, 13 + 2 * k, 32'h20), rtype(1, 2, 14 + 2 * k, 32'h20),
               32'h800 + 32'(8 * k));
    drain();
    repeat (3) step();

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
`ifdef ISSUE_STATS_EN
    chk("dual_cnt", 32'(DualCnt), 32'(expDual));
    chk("single_cnt", 32'(SingleCnt), 32'(expSingle));
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
